wb_dram_pattern_tester: RTL and testbench

Wishbone classic master that drives the LiteDRAM core's user_port_wishbone_0 (256-bit data, 25-bit word address). Once start is pulsed and init_done is high, it writes NUM_WORDS words of a selectable pattern from BASE_ADDR upward. It then reads the same words back, compares each against the expected pattern, and reports pass/fail, an error count and the first failing address. It replaces the empty test FSM in the board top level and runs on the core's user clock.

---
 rtl/dram_test_pkg.sv | 51 +++++
 rtl/dram_pattern_gen.sv | 20 ++
 rtl/wb_dram_pattern_tester.sv | 152 +++++++++++++++
 tb/tb_wb_dram_pattern_tester.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dram_test_pkg.sv
// Shared types and test-pattern definitions for the Wishbone DRAM pattern tester.
package dram_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_WRITE,
    S_READ,
    S_WAIT_READ,
    S_CHECK,
    S_DONE
  } test_state_t;

  localparam int PAT_ADR_W  = 25;
  localparam int PAT_DATA_W = 256;

  localparam logic [7:0] PAT_A5 = 8'hA5;
  localparam logic [7:0] PAT_5A = 8'h5A;
  localparam logic [7:0] PAT_FF = 8'hFF;
  localparam logic [7:0] PAT_00 = 8'h00;
  localparam logic [7:0] PAT_F0 = 8'hF0;
  localparam logic [7:0] PAT_0F = 8'h0F;
  localparam logic [7:0] PAT_AA = 8'hAA;
  localparam logic [7:0] PAT_55 = 8'h55;

  // One 32-bit lane; sel 8 tags each lane with its index and the word address.
  function automatic logic [31:0] pattern_lane(input logic [3:0] sel,
                                               input logic [PAT_ADR_W-1:0] adr,
                                               input logic [2:0] lane);
    logic [7:0] b;
    case (sel)
      4'd1:    b = PAT_5A;
      4'd2:    b = PAT_FF;
      4'd3:    b = PAT_00;
      4'd4:    b = PAT_F0;
      4'd5:    b = PAT_0F;
      4'd6:    b = PAT_AA;
      4'd7:    b = PAT_55;
      default: b = PAT_A5;
    endcase
    return (sel == 4'd8) ? {4'h0, lane, adr} : {4{b}};
  endfunction

  function automatic logic [PAT_DATA_W-1:0] pattern_word(input logic [3:0] sel,
                                                        input logic [PAT_ADR_W-1:0] adr);
    logic [PAT_DATA_W-1:0] w;
    for (int i = 0; i < PAT_DATA_W / 32; i++) w[i*32 +: 32] = pattern_lane(sel, adr, 3'(i));
    return w;
  endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// Expected-data generator; one instance feeds both write data and read-back compare.
module dram_pattern_gen
  import dram_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 256
) (
  input  logic [3:0]            sel,
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic [DATA_WIDTH-1:0] pattern
);
  localparam int LANES = DATA_WIDTH / 32;

  logic [PAT_ADR_W-1:0] adr_ext;
  assign adr_ext = PAT_ADR_W'(adr);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pattern[i*32 +: 32] = pattern_lane(sel, adr_ext, 3'(i));
  end
endmodule

// File: rtl/wb_dram_pattern_tester.sv
// Wishbone classic master: writes a pattern over a DRAM window, reads it back and
// reports pass/fail, error count, first failing address and access timeout.
module wb_dram_pattern_tester
  import dram_test_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 25,
  parameter int                  DATA_WIDTH     = 256,
  parameter int                  NUM_WORDS      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                  TIMEOUT_CYCLES = 65535,
  localparam int                 SEL_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            pattern_sel,
  input  logic                  init_done,
  input  logic                  init_error,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [SEL_WIDTH-1:0]  wb_sel,
  output logic [DATA_WIDTH-1:0] wb_dat_w,
  input  logic [DATA_WIDTH-1:0] wb_dat_r,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  test_state_t state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [3:0]            pat_sel;
  logic [DATA_WIDTH-1:0] rd_q, expected;
  logic [ADDR_WIDTH-1:0] adr_cur;
  logic [TO_W-1:0]       to_cnt;
  logic                  bus_act, init_fail_q, last, term, to_hit, err_evt;

  assign adr_cur = BASE_ADDR + ADDR_WIDTH'(idx);
  assign last    = (idx == LAST_IDX);
  assign idx_nxt = last ? '0 : idx + 1'b1;
  assign term    = wb_ack | wb_err;
  assign to_hit  = (to_cnt == TO_LAST);

  dram_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_gen (
    .sel    (pat_sel),
    .adr    (adr_cur),
    .pattern(expected)
  );

  assign wb_cyc = bus_act;
  assign wb_stb = bus_act;
  assign wb_sel = '1;
  assign busy   = (state != S_IDLE) && (state != S_DONE);
  assign done   = (state == S_DONE);
  assign pass   = done && !init_fail_q && (err_count == 16'd0) && !timeout;
  assign fail   = done && !pass;

  // A bus error in either wait state or a data miscompare in CHECK is one error.
  assign err_evt = (((state == S_WAIT_WRITE) || (state == S_WAIT_READ)) && wb_err) ||
                   ((state == S_CHECK) && (rd_q != expected));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        if (init_error)     state_nxt = S_DONE;
        else if (init_done) state_nxt = S_WRITE;
      end
      S_WRITE:      state_nxt = S_WAIT_WRITE;
      S_WAIT_WRITE: if (term)        state_nxt = last ? S_READ : S_WRITE;
                    else if (to_hit) state_nxt = S_DONE;
      S_READ:       state_nxt = S_WAIT_READ;
      S_WAIT_READ:  if (wb_err)      state_nxt = last ? S_DONE : S_READ;
                    else if (wb_ack) state_nxt = S_CHECK;
                    else if (to_hit) state_nxt = S_DONE;
      S_CHECK:      state_nxt = last ? S_DONE : S_READ;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_act        <= 1'b0;
      wb_we          <= 1'b0;
      wb_adr         <= '0;
      wb_dat_w       <= '0;
      idx            <= '0;
      pat_sel        <= '0;
      rd_q           <= '0;
      to_cnt         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      init_fail_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start && (init_error || init_done)) begin
          err_count      <= '0;
          first_err_addr <= '0;
          timeout        <= 1'b0;
          init_fail_q    <= init_error;
          idx            <= '0;
          pat_sel        <= pattern_sel;
        end
        S_WRITE, S_READ: begin
          bus_act <= 1'b1;
          wb_we   <= (state == S_WRITE);
          wb_adr  <= adr_cur;
          to_cnt  <= '0;
          if (state == S_WRITE) wb_dat_w <= expected;
        end
        S_WAIT_WRITE, S_WAIT_READ: begin
          if (term) begin
            bus_act <= 1'b0;
            wb_we   <= 1'b0;
            // A clean read ack defers the index step to CHECK.
            if ((state == S_WAIT_READ) && !wb_err) rd_q <= wb_dat_r;
            else                                  idx  <= idx_nxt;
          end else if (to_hit) begin
            bus_act <= 1'b0;
            wb_we   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_CHECK: idx <= idx_nxt;
        default: ;
      endcase
      if (err_evt) begin
        if (err_count == 16'd0)     first_err_addr <= wb_adr;
        if (err_count != 16'hFFFF) err_count      <= err_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_dram_pattern_tester.sv
// Directed bench for wb_dram_pattern_tester with a small configurable Wishbone memory model.
module tb_wb_dram_pattern_tester;
  localparam int AW = 25;
  localparam int DW = 256;
  localparam int NW = 16;
  localparam int TO = 100;
  localparam logic [AW-1:0] BASE = 25'h1FFFFF8;

  logic            sys_clk = 1'b0;
  logic            rst_n = 1'b0, start = 1'b0, init_done = 1'b0, init_error = 1'b0;
  logic [3:0]      pattern_sel = 4'd0;
  logic            wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [AW-1:0]   wb_adr, first_err_addr;
  logic [DW/8-1:0] wb_sel;
  logic [DW-1:0]   wb_dat_w;
  logic [DW-1:0]   wb_dat_r = '0;
  logic            busy, done, pass, fail, timeout;
  logic [15:0]     err_count;

  always #5 sys_clk = ~sys_clk;

  wb_dram_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .init_done(init_done), .init_error(init_error),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  // Memory model: registered ack after ack_lat extra cycles; optional hang, bus error, corruption.
  logic [DW-1:0] mem [0:31];
  logic [AW-1:0] wr_log [0:63];
  int            ack_lat = 0, lat_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic          hang_en = 1'b0, err_en = 1'b0, cor_en = 1'b0;
  logic [AW-1:0] hang_adr = '0, err_adr = '0, cor_a = '0, cor_b = '0;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack <= 1'b0; wb_err <= 1'b0; lat_cnt <= 0;
    end else begin
      wb_ack <= 1'b0; wb_err <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
        if (hang_en && wb_adr == hang_adr) lat_cnt <= 0;
        else if (lat_cnt < ack_lat) lat_cnt <= lat_cnt + 1;
        else begin
          lat_cnt <= 0;
          if (err_en && !wb_we && wb_adr == err_adr) wb_err <= 1'b1;
          else begin
            wb_ack <= 1'b1;
            if (wb_we) begin
              mem[wb_adr[4:0]]   <= wb_dat_w;
              wr_log[wr_cnt[5:0]] <= wb_adr;
              wr_cnt             <= wr_cnt + 1;
            end else begin
              wb_dat_r <= mem[wb_adr[4:0]] ^
                          {{(DW-1){1'b0}}, cor_en && (wb_adr == cor_a || wb_adr == cor_b)};
              rd_cnt   <= rd_cnt + 1;
            end
          end
        end
      end else lat_cnt <= 0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then scramble pattern_sel to prove it was latched; wait for done.
  task automatic run_test(input logic [3:0] sel, input int limit, output int edges);
    @(negedge sys_clk); pattern_sel = sel; start = 1'b1;
    @(negedge sys_clk); start = 1'b0; pattern_sel = 4'd9;
    edges = 1;
    while (!done && edges < limit) begin @(negedge sys_clk); edges++; end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    int edges, w0, r0, k, nbad;
    logic [DW-1:0] a5w;
    logic [DW-1:0] m;
    a5w = {32{8'hA5}};

    #23;
    chk("rst_cyc", 64'(wb_cyc), 64'd0);
    chk("rst_stb", 64'(wb_stb), 64'd0);
    chk("rst_sel", 64'(wb_sel), 64'hFFFF_FFFF);
    chk("rst_busy_done", 64'({busy, done, pass, fail, timeout}), 64'd0);
    chk("rst_err", 64'({err_count, first_err_addr}), 64'd0);
    @(negedge sys_clk); rst_n = 1'b1;

    // start without calibration is ignored
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("nocal_idle", 64'({busy, done, wb_cyc}), 64'd0);

    // zero-wait, sel 0: 16*3 + 16*4 cycles plus the WRITE-entry edge
    init_done = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    run_test(4'd0, 400, edges);
    chk("t1_latency", 64'(edges), 64'd113);
    chk("t1_pass_fail", 64'({pass, fail, busy}), 64'b100);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_writes", 64'(wr_cnt - w0), 64'd16);
    chk("t1_reads", 64'(rd_cnt - r0), 64'd16);
    chk("t1_first_adr", 64'(wr_log[w0[5:0]]), 64'h1FFFFF8);
    nbad = 0;
    for (int i = 0; i < 32; i++) if (i < 8 || i >= 24) begin
      m = mem[i];
      if (m !== a5w) nbad++;
    end
    chk("t1_a5_data", 64'(nbad), 64'd0);

    // 5-cycle ack latency, sel 8, address wrap
    ack_lat = 5; w0 = wr_cnt;
    run_test(4'd8, 2000, edges);
    chk("t2_pass", 64'({pass, fail}), 64'b10);
    m = mem[5];
    chk("t2_lane3_adr5", 64'(m[127:96]), 64'h0600_0005);
    m = mem[24];
    chk("t2_lane0_adr1fffff8", 64'(m[31:0]), 64'h01FF_FFF8);
    chk("t2_lane7_adr1fffff8", 64'(m[255:224]), 64'h0FFF_FFF8);
    k = w0 + 8;
    chk("t2_wrap_adr", 64'(wr_log[k[5:0]]), 64'h0);
    k = w0 + 15;
    chk("t2_last_adr", 64'(wr_log[k[5:0]]), 64'h7);
    ack_lat = 0;

    // corrupted reads at adr 3 and 5
    cor_en = 1'b1; cor_a = 25'd3; cor_b = 25'd5;
    run_test(4'd0, 400, edges);
    chk("t3_err_count", 64'(err_count), 64'd2);
    chk("t3_first_err", 64'(first_err_addr), 64'd3);
    chk("t3_fail", 64'({pass, fail, timeout}), 64'b010);
    cor_en = 1'b0;

    // bus error on read of adr 2 counts once and skips CHECK
    err_en = 1'b1; err_adr = 25'd2; r0 = rd_cnt;
    run_test(4'd0, 400, edges);
    chk("t4_err_count", 64'(err_count), 64'd1);
    chk("t4_first_err", 64'(first_err_addr), 64'd2);
    chk("t4_fail", 64'({pass, fail}), 64'b01);
    chk("t4_reads", 64'(rd_cnt - r0), 64'd15);
    err_en = 1'b0;

    // slave never acks word 2 (adr 1FFFFFA)
    hang_en = 1'b1; hang_adr = 25'h1FFFFFA;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    k = 0;
    while (!(wb_stb && wb_adr == hang_adr) && k < 200) begin @(negedge sys_clk); k++; end
    chk("t5_hang_seen", 64'(k < 200), 64'd1);
    k = 0;
    while (wb_stb && k < 300) begin @(negedge sys_clk); k++; end
    chk("t5_stb_drop_cycles", 64'(k), 64'd100);
    chk("t5_result", 64'({done, timeout, pass, fail, busy, wb_cyc}), 64'b110100);
    hang_en = 1'b0;

    // calibration failure: straight to DONE with no bus traffic
    init_error = 1'b1; w0 = wr_cnt;
    run_test(4'd0, 10, edges);
    chk("t6_latency", 64'(edges), 64'd1);
    chk("t6_fail", 64'({pass, fail, wb_cyc}), 64'b010);
    chk("t6_err", 64'(err_count), 64'd0);
    chk("t6_no_writes", 64'(wr_cnt - w0), 64'd0);
    init_error = 1'b0;

    // reset during a write wait drops the bus asynchronously
    ack_lat = 5;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    k = 0;
    while (!(wb_stb && wb_we) && k < 50) begin @(negedge sys_clk); k++; end
    chk("t7_stb_seen", 64'(k < 50), 64'd1);
    @(negedge sys_clk); #2 rst_n = 1'b0; #1;
    chk("t7_async_drop", 64'({wb_cyc, wb_stb, busy, done}), 64'd0);
    @(negedge sys_clk); rst_n = 1'b1; ack_lat = 0; w0 = wr_cnt;
    run_test(4'd0, 400, edges);
    chk("t7_restart_pass", 64'({pass, fail}), 64'b10);
    chk("t7_restart_adr", 64'(wr_log[w0[5:0]]), 64'h1FFFFF8);
    chk("t7_restart_writes", 64'(wr_cnt - w0), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
